// File: rtl/gpu_cmd_ctrl_if.sv
// gpu_cmd_ctrl_if -- command and glyph-RAM write bundle for gpu_cmd_ctrl.
//   cmd_valid/cmd_ready : command handshake (accepted when both are high at a rising edge)
//   cmd_code/cmd_data   : 00 STORE, 01 MOVE, 10 DISPLAY, 11 CLEAR; 8-bit operand
//   mem_we/mem_addr     : glyph RAM write strobe and cell index y*TEXT_W+x
//   mem_buf/mem_wdata   : target (back) buffer and write data
// master = command source / RAM side, slave = controller.
interface gpu_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_code;
    logic [7:0]  cmd_data;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic        mem_buf;
    logic [7:0]  mem_wdata;

    modport master (
        output cmd_valid, cmd_code, cmd_data,
        input  cmd_ready, mem_we, mem_addr, mem_buf, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_data,
        output cmd_ready, mem_we, mem_addr, mem_buf, mem_wdata
    );
endinterface

// File: rtl/gpu_cmd_ctrl.sv
// gpu_cmd_ctrl -- text-mode command controller for a double-buffered glyph RAM.
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   bus         : gpu_cmd_ctrl_if.slave (command handshake + RAM write port)
//   vblank      : one-cycle pulse at start of vertical blank
//   disp_req    : scan-out owns the RAM port this cycle (always wins)
//   active_buf  : buffer being scanned out; writes go to the other one
//   cursor_x/y  : text cursor
//   busy        : controller not in IDLE
module gpu_cmd_ctrl #(
    parameter int TEXT_W = 80,
    parameter int TEXT_H = 60
) (
    input  logic              clk,
    input  logic              reset,
    gpu_cmd_ctrl_if.slave     bus,
    input  logic              vblank,
    input  logic              disp_req,
    output logic              active_buf,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);
    localparam logic [12:0] LAST = 13'(TEXT_W * TEXT_H - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, SWAP_WAIT} state_t;

    state_t      state, state_nxt;
    // addr doubles as the CLEAR sweep index, so it is what the RAM sees
    // in both WRITE and CLEAR and naturally holds while stalled.
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        accept;
    logic [6:0]  adv_x;
    logic [5:0]  adv_y;
    logic [7:0]  sum_x;
    logic [6:0]  sum_y;

    assign we            = (state == WRITE || state == CLEAR) && !disp_req;
    assign accept        = bus.cmd_valid && (state == IDLE);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_buf   = ~active_buf;
    assign busy          = (state != IDLE);

    // Cursor advance with row and screen wrap.
    always_comb begin
        adv_x = cursor_x + 7'd1;
        adv_y = cursor_y;
        if (cursor_x == 7'(TEXT_W - 1)) begin
            adv_x = 7'd0;
            adv_y = (cursor_y == 6'(TEXT_H - 1)) ? 6'd0 : cursor_y + 6'd1;
        end
    end

    // MOVE sums are widened so the modulo sees the full range (<=206 / <=122).
    assign sum_x = 8'(cursor_x) + 8'(bus.cmd_data[6:0]);
    assign sum_y = 7'(cursor_y) + 7'(bus.cmd_data[5:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_code)
                        2'b00:   state_nxt = WRITE;
                        2'b10:   state_nxt = SWAP_WAIT;
                        2'b11:   state_nxt = CLEAR;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            WRITE:     if (we) state_nxt = IDLE;
            CLEAR:     if (we && addr == LAST) state_nxt = IDLE;
            SWAP_WAIT: if (vblank) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            active_buf <= 1'b0;
            cursor_x   <= 7'd0;
            cursor_y   <= 6'd0;
            addr       <= 13'd0;
            wdata      <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd_code)
                            2'b00: begin
                                addr  <= 13'(cursor_y) * 13'(TEXT_W) + 13'(cursor_x);
                                wdata <= bus.cmd_data;
                            end
                            2'b01: begin
                                if (bus.cmd_data[7])
                                    cursor_x <= 7'(sum_x % 8'(TEXT_W));
                                else
                                    cursor_y <= 6'(sum_y % 7'(TEXT_H));
                            end
                            2'b11: begin
                                addr  <= 13'd0;
                                wdata <= 8'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    if (we) begin
                        cursor_x <= adv_x;
                        cursor_y <= adv_y;
                    end
                end
                CLEAR: begin
                    if (we) begin
                        if (addr == LAST) begin
                            cursor_x <= 7'd0;
                            cursor_y <= 6'd0;
                        end else begin
                            addr <= addr + 13'd1;
                        end
                    end
                end
                SWAP_WAIT: if (vblank) active_buf <= ~active_buf;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_cmd_ctrl.sv
// tb_gpu_cmd_ctrl -- directed scenarios plus randomized command traffic,
// checked every cycle against a transaction-level model (expected write queue,
// linear cursor position, pending swap flag).
module tb_gpu_cmd_ctrl;
    localparam int W = 80;
    localparam int H = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vblank = 1'b0;
    logic       disp_req = 1'b0;
    logic       active_buf;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       busy;

    gpu_cmd_ctrl_if bus ();

    gpu_cmd_ctrl #(.TEXT_W(W), .TEXT_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .vblank     (vblank),
        .disp_req   (disp_req),
        .active_buf (active_buf),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  m_x, m_y;
    bit  m_buf, m_swap;

    int  n_chk = 0, n_fail = 0;
    int  wr_cnt = 0, last_waddr = -1, last_wdata = -1;
    bit  accepted;
    int  io_mode = 0;   // 0 manual, 1 random, 2 disp_req toggling

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_x = 0; m_y = 0; m_buf = 0; m_swap = 0;
    endtask

    function automatic bit m_idle();
        return exp_q.size() == 0 && !m_swap;
    endfunction

    task automatic m_accept(input logic [1:0] c, input logic [7:0] d);
        int p;
        case (c)
            2'b00: begin
                exp_q.push_back('{addr: m_y * W + m_x, data: int'(d)});
                p = (m_y * W + m_x + 1) % (W * H);
                m_x = p % W; m_y = p / W;
            end
            2'b01: if (d[7]) m_x = (m_x + int'(d[6:0])) % W;
                   else      m_y = (m_y + int'(d[5:0])) % H;
            2'b10: m_swap = 1;
            default: begin
                for (int i = 0; i < W * H; i++) exp_q.push_back('{addr: i, data: 0});
                m_x = 0; m_y = 0;
            end
        endcase
    endtask

    // One clock: set random inputs, observe at negedge, return at posedge+1.
    task automatic cyc();
        case (io_mode)
            1: begin
                disp_req = ($urandom_range(0, 99) < 30);
                vblank   = ($urandom_range(0, 99) < 6);
            end
            2: begin
                disp_req = ~disp_req;
                vblank   = 1'b0;
            end
            default: ;
        endcase
        @(negedge clk);
        if (reset) begin
            m_reset();
        end else begin
            chk("ready", bus.cmd_ready, m_idle());
            chk("busy", busy, !m_idle());
            chk("active_buf", active_buf, m_buf);
            chk("mem_buf", bus.mem_buf, !m_buf);
            if (m_idle()) begin
                chk("cursor_x", cursor_x, m_x);
                chk("cursor_y", cursor_y, m_y);
            end
            if (exp_q.size() == 0) begin
                chk("we_quiet", bus.mem_we, 0);
            end else begin
                chk("we", bus.mem_we, !disp_req);
                chk("addr", bus.mem_addr, exp_q[0].addr);
                chk("wdata", bus.mem_wdata, exp_q[0].data);
                if (bus.mem_we) begin
                    last_waddr = int'(bus.mem_addr);
                    last_wdata = int'(bus.mem_wdata);
                    wr_cnt++;
                    void'(exp_q.pop_front());
                end
            end
            if (m_swap && vblank) begin
                m_buf = !m_buf;
                m_swap = 0;
            end
            if (bus.cmd_valid && bus.cmd_ready && m_idle()) begin
                accepted = 1;
                m_accept(bus.cmd_code, bus.cmd_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        int n = 0;
        accepted = 0;
        bus.cmd_valid = 1'b1; bus.cmd_code = c; bus.cmd_data = d;
        while (!accepted && n < 20000) begin cyc(); n++; end
        if (!accepted) chk("accept_timeout", 0, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(m_idle() && bus.cmd_ready) && n < 20000) begin cyc(); n++; end
        if (n >= 20000) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    initial begin
        int w0, n, clears;
        logic [1:0] c;
        bus.cmd_valid = 1'b0; bus.cmd_code = 2'b00; bus.cmd_data = 8'h00;
        m_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset state, then single STORE.
        cyc();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_abuf", active_buf, 0);
        w0 = wr_cnt;
        issue(2'b00, 8'h41);
        drain(); cyc();
        chk("s1_writes", wr_cnt - w0, 1);
        chk("s1_addr", last_waddr, 0);
        chk("s1_data", last_wdata, 8'h41);
        chk("s1_cx", cursor_x, 1);
        chk("s1_cy", cursor_y, 0);

        // MOVE x+79 then two STOREs across the row boundary.
        do_reset();
        issue(2'b01, 8'hCF);
        issue(2'b00, 8'h42); drain();
        chk("mv_a0", last_waddr, 79);
        issue(2'b00, 8'h42); drain(); cyc();
        chk("mv_a1", last_waddr, 80);
        chk("mv_cx", cursor_x, 1);
        chk("mv_cy", cursor_y, 1);

        // STORE stalled by display for 5 cycles.
        disp_req = 1'b1;
        w0 = wr_cnt;
        issue(2'b00, 8'h5A);
        for (int i = 0; i < 5; i++) cyc();
        chk("stall_nowrite", wr_cnt - w0, 0);
        disp_req = 1'b0;
        cyc();
        chk("stall_write", wr_cnt - w0, 1);
        chk("stall_addr", last_waddr, 81);

        // CLEAR with disp_req toggling.
        io_mode = 2;
        w0 = wr_cnt;
        issue(2'b11, 8'h00);
        drain();
        io_mode = 0; disp_req = 1'b0;
        cyc();
        chk("clr_count", wr_cnt - w0, W * H);
        chk("clr_last", last_waddr, W * H - 1);
        chk("clr_cx", cursor_x, 0);
        chk("clr_cy", cursor_y, 0);
        chk("clr_ready", bus.cmd_ready, 1);

        // DISPLAY with vblank in the accept cycle, real pulse 10 cycles later.
        vblank = 1'b1;
        issue(2'b10, 8'h00);
        vblank = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        chk("dsp_before", active_buf, 0);
        vblank = 1'b1; cyc(); vblank = 1'b0; cyc();
        chk("dsp_after", active_buf, 1);
        chk("dsp_membuf", bus.mem_buf, 0);

        // Reset in the middle of CLEAR at index 100.
        issue(2'b11, 8'h00);
        n = 0;
        while (exp_q.size() > W * H - 100 && n < 1000) begin cyc(); n++; end
        chk("mid_clr_reached", exp_q.size(), W * H - 100);
        reset = 1'b1; cyc(); reset = 1'b0;
        cyc();
        chk("rc_we", bus.mem_we, 0);
        chk("rc_abuf", active_buf, 0);
        chk("rc_cx", cursor_x, 0);
        chk("rc_cy", cursor_y, 0);
        chk("rc_ready", bus.cmd_ready, 1);

        // Randomized traffic.
        io_mode = 1;
        clears = 2;
        for (int k = 0; k < 400; k++) begin
            c = 2'($urandom_range(0, 3));
            if (c == 2'b11) begin
                if (clears > 0) clears--;
                else c = 2'b00;
            end
            issue(c, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) cyc();
            if (k == 200) begin
                issue(2'b10, 8'h00);
                reset = 1'b1; cyc(); reset = 1'b0;
            end
        end
        drain();
        cyc();
        chk("final_idle", bus.cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
